// File: rtl/lbus_arbiter.sv
// Two-master round-robin arbiter for the 16-bit local bus.
// Each granted transaction gets a fixed address setup time followed by a fixed-width active-low strobe.
module lbus_arbiter #(
    parameter int SETUP   = 8,
    parameter int PULSE_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        rw0,
    input  logic        rw1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic [15:0] lbus_a,
    output logic [15:0] lbus_dw,
    input  logic [15:0] lbus_dr,
    output logic        lbus_wr,
    output logic        lbus_rd,
    output logic        grant,
    output logic        busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_DONE} state_t;

    localparam logic [7:0] SETUP_LAST = 8'(SETUP - 1);
    localparam logic [7:0] PULSE_LAST = 8'(PULSE_W - 1);

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg;
    logic [15:0] lbus_a_reg, lbus_dw_reg;
    logic        rw_reg, grant_reg, last_reg;
    logic        lbus_wr_reg, lbus_rd_reg;

    logic        grant_go, setup_end, strobe_end, sel;
    logic [1:0]  req_vec, rw_vec, ack_vec;
    logic [15:0] addr_arr  [2];
    logic [15:0] wdata_arr [2];
    logic [15:0] rdata_arr [2];

    assign req_vec      = {req1, req0};
    assign rw_vec       = {rw1, rw0};
    assign addr_arr[0]  = addr0;
    assign addr_arr[1]  = addr1;
    assign wdata_arr[0] = wdata0;
    assign wdata_arr[1] = wdata1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (|req_vec)  state_next = ST_SETUP;
            ST_SETUP:  if (setup_end) state_next = ST_STROBE;
            ST_STROBE: if (strobe_end) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // On a tie the master that did not own the previous transaction wins.
    always_comb begin
        busy       = (state_reg != ST_IDLE);
        grant_go   = (state_reg == ST_IDLE) && (|req_vec);
        setup_end  = (state_reg == ST_SETUP) && (cnt_reg == SETUP_LAST);
        strobe_end = (state_reg == ST_STROBE) && (cnt_reg == PULSE_LAST);
        sel        = (req_vec == 2'b11) ? ~last_reg : req_vec[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg     <= '0;
            lbus_a_reg  <= '0;
            lbus_dw_reg <= '0;
            rw_reg      <= 1'b0;
            grant_reg   <= 1'b0;
            last_reg    <= 1'b1;
            lbus_wr_reg <= 1'b1;
            lbus_rd_reg <= 1'b1;
        end else if (grant_go) begin
            lbus_a_reg  <= addr_arr[sel];
            lbus_dw_reg <= wdata_arr[sel];
            rw_reg      <= rw_vec[sel];
            grant_reg   <= sel;
            cnt_reg     <= '0;
        end else if (setup_end) begin
            cnt_reg <= '0;
            if (rw_reg) begin
                lbus_wr_reg <= 1'b0;
            end else begin
                lbus_rd_reg <= 1'b0;
            end
        end else if (strobe_end) begin
            cnt_reg     <= '0;
            lbus_wr_reg <= 1'b1;
            lbus_rd_reg <= 1'b1;
            last_reg    <= grant_reg;
        end else if (state_reg == ST_SETUP || state_reg == ST_STROBE) begin
            cnt_reg <= cnt_reg + 8'd1;
        end
    end

    // Per-master completion pulse and read-data holding register.
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        logic        ack_reg;
        logic [15:0] rdata_reg;
        logic        mine;

        assign mine = strobe_end && (grant_reg == 1'(gi));

        always_ff @(posedge clk) begin
            if (rst) begin
                ack_reg   <= 1'b0;
                rdata_reg <= '0;
            end else begin
                ack_reg <= mine;
                if (mine && !rw_reg) begin
                    rdata_reg <= lbus_dr;
                end
            end
        end

        assign ack_vec[gi]   = ack_reg;
        assign rdata_arr[gi] = rdata_reg;
    end

    assign ack0    = ack_vec[0];
    assign ack1    = ack_vec[1];
    assign rdata0  = rdata_arr[0];
    assign rdata1  = rdata_arr[1];
    assign lbus_a  = lbus_a_reg;
    assign lbus_dw = lbus_dw_reg;
    assign lbus_wr = lbus_wr_reg;
    assign lbus_rd = lbus_rd_reg;
    assign grant   = grant_reg;

endmodule

// File: tb/tb_lbus_arbiter.sv
// Scoreboard bench for lbus_arbiter: directed transactions push expectations, a monitor checks each ack.
// A second instance with SETUP=PULSE_W=1 checks the minimum-timing corner.
module tb_lbus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, rw0, rw1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, lbus_wr, lbus_rd, grant, busy;
    logic [15:0] rdata0, rdata1, lbus_a, lbus_dw, lbus_dr;

    logic        f_req0, f_ack0, f_ack1, f_wr, f_rd, f_grant, f_busy;
    logic [15:0] f_rdata0, f_rdata1, f_a, f_dw;

    always #5 clk = ~clk;

    // Bus slave: read data is valid only while the read strobe is low.
    assign lbus_dr = lbus_rd ? 16'hDEAD : (lbus_a ^ 16'hA4C3);

    lbus_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .lbus_a(lbus_a), .lbus_dw(lbus_dw), .lbus_dr(lbus_dr),
        .lbus_wr(lbus_wr), .lbus_rd(lbus_rd), .grant(grant), .busy(busy)
    );

    lbus_arbiter #(.SETUP(1), .PULSE_W(1)) dut_fast (
        .clk(clk), .rst(rst),
        .req0(f_req0), .req1(1'b0), .rw0(1'b1), .rw1(1'b0),
        .addr0(16'h0042), .addr1(16'h0000), .wdata0(16'h1111), .wdata1(16'h0000),
        .ack0(f_ack0), .ack1(f_ack1), .rdata0(f_rdata0), .rdata1(f_rdata1),
        .lbus_a(f_a), .lbus_dw(f_dw), .lbus_dr(16'h3C3C),
        .lbus_wr(f_wr), .lbus_rd(f_rd), .grant(f_grant), .busy(f_busy)
    );

    typedef struct {
        int          master;
        logic        rw;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] r0;
        logic [15:0] r1;
        int          gap;
    } exp_t;

    exp_t        sb[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [15:0] m_rdata0, m_rdata1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int m, input logic rw, input logic [15:0] a, input logic [15:0] d, input int gap);
        exp_t e;
        e.master = m; e.rw = rw; e.addr = a; e.wdata = d;
        e.r0 = m_rdata0; e.r1 = m_rdata1; e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input int m, input int limit);
        int n = 0;
        while (!((m == 0) ? ack0 : ack1)) begin
            @(negedge clk);
            n++;
            if (n > limit) begin
                chk($sformatf("ack%0d_timeout", m), 32'd0, 32'd1);
                return;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_rdata0 = '0; m_rdata1 = '0;
    endtask

    // Monitor: measures strobe position/width per transaction and checks each ack against the scoreboard.
    int   cyc = 0, k = 0, last_ack_cyc = 0;
    int   wr_cnt = 0, rd_cnt = 0, wr_first = -1, rd_first = -1;
    logic prev_busy = 1'b0, overlap = 1'b0, ack_pending = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (ack_pending) begin
            chk("ack_one_cycle", {30'd0, ack1, ack0}, 32'd0);
            ack_pending = 1'b0;
        end
        if (rst) begin
            prev_busy = 1'b0;
        end else begin
            if (busy && !prev_busy) begin
                k = 0; wr_cnt = 0; rd_cnt = 0; wr_first = -1; rd_first = -1; overlap = 1'b0;
            end else if (busy) begin
                k++;
            end
            if (!lbus_wr) begin
                if (wr_cnt == 0) wr_first = k;
                wr_cnt++;
            end
            if (!lbus_rd) begin
                if (rd_cnt == 0) rd_first = k;
                rd_cnt++;
            end
            if (!lbus_wr && !lbus_rd) overlap = 1'b1;
            if (ack0 || ack1) begin
                ack_pending = 1'b1;
                if (sb.size() == 0) begin
                    chk("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("ack_id", {30'd0, ack1, ack0}, (e.master == 0) ? 32'd1 : 32'd2);
                    chk("ack_latency", k, 32'd16);
                    chk("grant", {31'd0, grant}, e.master);
                    chk("lbus_a", {16'd0, lbus_a}, {16'd0, e.addr});
                    chk("lbus_dw", {16'd0, lbus_dw}, {16'd0, e.wdata});
                    chk("wr_low_cycles", wr_cnt, e.rw ? 32'd8 : 32'd0);
                    chk("rd_low_cycles", rd_cnt, e.rw ? 32'd0 : 32'd8);
                    chk("strobe_fall_cycle", e.rw ? wr_first : rd_first, 32'd8);
                    chk("strobe_overlap", {31'd0, overlap}, 32'd0);
                    chk("rdata0", {16'd0, rdata0}, {16'd0, e.r0});
                    chk("rdata1", {16'd0, rdata1}, {16'd0, e.r1});
                    if (e.gap != 0) chk("ack_gap", cyc - last_ack_cyc, e.gap);
                end
                last_ack_cyc = cyc;
            end
        end
        prev_busy = busy;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] fw_mask, fr_mask, fa_mask;
        int          n;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; rw0 = 1'b0; rw1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; f_req0 = 1'b0;
        m_rdata0 = '0; m_rdata1 = '0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_lbus_a", {16'd0, lbus_a}, 32'd0);
        chk("rst_lbus_dw", {16'd0, lbus_dw}, 32'd0);
        chk("rst_rdata", {rdata1, rdata0}, 32'd0);
        chk("rst_strobes", {30'd0, lbus_wr, lbus_rd}, 32'd3);
        chk("rst_ack_grant_busy", {28'd0, ack0, ack1, grant, busy}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Master 0 write
        rw0 = 1'b1; addr0 = 16'h0002; wdata0 = 16'h0001;
        push_exp(0, 1'b1, 16'h0002, 16'h0001, 0);
        req0 = 1'b1;
        wait_ack(0, 40);
        req0 = 1'b0;
        repeat (3) @(negedge clk);

        // Master 1 read; its inputs change after grant and master 0's are noise
        rw1 = 1'b0; addr1 = 16'h0100; wdata1 = 16'h0F0F;
        rw0 = 1'b1; addr0 = 16'h7F7F; wdata0 = 16'h3333;
        m_rdata1 = 16'hA5C3;
        push_exp(1, 1'b0, 16'h0100, 16'h0F0F, 0);
        req1 = 1'b1;
        repeat (3) @(negedge clk);
        addr1 = 16'h7777; rw1 = 1'b1; wdata1 = 16'h9999;
        wait_ack(1, 40);
        req1 = 1'b0;
        repeat (3) @(negedge clk);

        // Simultaneous requests after reset: master 0 first, then master 1 one period later
        do_reset();
        rw0 = 1'b1; addr0 = 16'h0010; wdata0 = 16'hBEEF;
        rw1 = 1'b1; addr1 = 16'h0020; wdata1 = 16'hCAFE;
        push_exp(0, 1'b1, 16'h0010, 16'hBEEF, 0);
        push_exp(1, 1'b1, 16'h0020, 16'hCAFE, 18);
        req0 = 1'b1; req1 = 1'b1;
        wait_ack(0, 40);
        req0 = 1'b0;
        wait_ack(1, 40);
        req1 = 1'b0;
        repeat (3) @(negedge clk);

        // Both held for six transactions: strict alternation, master 1 reads
        rw0 = 1'b1; addr0 = 16'h1000; wdata0 = 16'h1234;
        rw1 = 1'b0; addr1 = 16'h2000; wdata1 = 16'h5555;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                push_exp(0, 1'b1, 16'h1000, 16'h1234, (i == 0) ? 0 : 18);
            end else begin
                m_rdata1 = 16'h84C3;
                push_exp(1, 1'b0, 16'h2000, 16'h5555, 18);
            end
        end
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_ack(i % 2, 40);
            if (i == 4) req0 = 1'b0;
            if (i == 5) req1 = 1'b0;
            if (i < 5) @(negedge clk);
        end
        repeat (3) @(negedge clk);

        // Reset in the 4th strobe-low cycle of a write
        rw0 = 1'b1; addr0 = 16'h0ABC; wdata0 = 16'h0DEF;
        req0 = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (!lbus_wr) n++;
        end
        chk("strobe_before_reset", n, 32'd4);
        rst = 1'b1; req0 = 1'b0;
        @(negedge clk);
        chk("abort_strobes", {30'd0, lbus_wr, lbus_rd}, 32'd3);
        chk("abort_busy_ack", {29'd0, busy, ack1, ack0}, 32'd0);
        chk("abort_lbus_a", {16'd0, lbus_a}, 32'd0);
        chk("abort_rdata1", {16'd0, rdata1}, 32'd0);
        rst = 1'b0;
        m_rdata0 = '0; m_rdata1 = '0;
        repeat (20) @(negedge clk);
        push_exp(0, 1'b1, 16'h0ABC, 16'h0DEF, 0);
        req0 = 1'b1;
        wait_ack(0, 40);
        req0 = 1'b0;
        repeat (3) @(negedge clk);

        // Minimum timing instance: back-to-back every 4 cycles
        fw_mask = '0; fr_mask = '0; fa_mask = '0;
        f_req0 = 1'b1;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            fw_mask[j] = ~f_wr;
            fr_mask[j] = ~f_rd;
            fa_mask[j] = f_ack0;
            if (j == 14) f_req0 = 1'b0;
        end
        chk("fast_wr_mask", {16'd0, fw_mask}, 32'h2222);
        chk("fast_ack_mask", {16'd0, fa_mask}, 32'h4444);
        chk("fast_rd_mask", {16'd0, fr_mask}, 32'h0000);
        repeat (3) @(negedge clk);
        chk("fast_idle", {30'd0, f_busy, f_ack1}, 32'd0);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/lbus_arbiter.md
# lbus_arbiter

Two-master arbiter and strobe sequencer for the 16-bit local bus that reaches the cryptographic module. Two on-chip requesters each present a read or write transaction with a level `req`/`ack` handshake: typically the PC-side host transceiver and an autonomous glitch/config sequencer. The block grants the bus round-robin, drives address and data with a fixed setup time and an active-low strobe of fixed width, and returns captured read data to the winning master.

## Interface
- `SETUP`, default 8: cycles that address/data are held before the strobe falls; legal range 1..255.
- `PULSE_W`, default 8: cycles the strobe is held low; legal range 1..255.
- `clk` in 1: single system clock, all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req0` / `req1` in 1: transaction request, level; held until the matching `ack`.
- `rw0` / `rw1` in 1: 1 = write, 0 = read; sampled at grant.
- `addr0` / `addr1` in 16: bus address; sampled at grant.
- `wdata0` / `wdata1` in 16: write data; sampled at grant.
- `ack0` / `ack1` out 1: one-cycle completion pulse.
- `rdata0` / `rdata1` out 16: read data of the master's last read; held until that master's next read completes.
- `lbus_a` out 16: local-bus address.
- `lbus_dw` out 16: local-bus write data.
- `lbus_dr` in 16: local-bus read data.
- `lbus_wr` / `lbus_rd` out 1: active-low write/read strobes.
- `grant` out 1: index of the master owning the current or last transaction.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- Reset values:
  - `lbus_a`, `lbus_dw`, `rdata0`, `rdata1` = 0.
  - `lbus_wr`, `lbus_rd` = 1.
  - `ack0`, `ack1`, `grant`, `busy` = 0.
  - Internal `last` = 1, so master 0 wins the first tie.
  - State = IDLE, 8-bit counter = 0.
- States: IDLE → SETUP → STROBE → DONE → IDLE.
- IDLE:
  - If exactly one `req` is high, grant that master.
  - If both are high, grant `~last`.
  - On grant:
    - Latch `addr`→`lbus_a`, `wdata`→`lbus_dw`, `rw` into an internal register.
    - Set `grant`; clear the counter; go to SETUP.
  - With no `req`, outputs hold.
- SETUP:
  - Counter increments each cycle.
  - When the counter = SETUP−1: drive `lbus_wr`=0 (write) or `lbus_rd`=0 (read), clear the counter, go to STROBE.
- STROBE:
  - Counter increments each cycle.
  - When the counter = PULSE_W−1:
    - Release the strobe to 1.
    - For a read, capture `lbus_dr` into `rdata[grant]`.
    - Assert `ack[grant]`=1, set `last`=`grant`, go to DONE.
- DONE:
  - Deassert `ack`; go to IDLE.
  - The requester must drop `req` before the next IDLE sample. A req still high in IDLE is a new transaction.
- Only one strobe is ever low at a time. `lbus_wr` and `lbus_rd` are never low together.
- `lbus_a` and `lbus_dw` stay stable from grant until the next grant; they are not cleared after a transaction.
- Write transactions leave `rdata*` unchanged.
- Requests are never queued beyond the level `req`:
  - A req dropped before grant is ignored.
  - A loser's req held during the other master's transaction is served next, because of round-robin.
- Changes to `rw*`, `addr*`, `wdata*` after grant have no effect on the current transaction.
- Unused `rw`, `addr`, `wdata` of the non-granted master are ignored.

## Timing
- The grant edge E0 is the posedge where IDLE samples `req`. Relative to E0:
  - `lbus_a` and `lbus_dw` are valid from E0.
  - The strobe falls at E0+SETUP.
  - The strobe rises and `ack` goes high at E0+SETUP+PULSE_W. `rdata` updates at the same edge, with `lbus_dr` sampled at that edge.
  - `ack` goes low at E0+SETUP+PULSE_W+1.
- With defaults: setup 8 cycles, strobe 8 cycles, `ack` 16 cycles after grant.
- Minimum period for back-to-back transactions = SETUP+PULSE_W+2 cycles (18 with defaults).
- `busy` rises at E0 and falls at the DONE→IDLE edge.
- Reset mid-operation: at the next posedge every output takes its reset value. In particular the strobe returns to 1 and no `ack` is issued. The aborted transaction is lost; the requester must re-request.

## Test plan
- Master 0 write, `addr0`=0x0002, `wdata0`=0x0001 → `lbus_a`=0x0002 and `lbus_dw`=0x0001 at E0. `lbus_wr` is low exactly in cycles E0+8..E0+15. `ack0` pulses once at E0+16. `lbus_rd` stays 1 throughout.
- Master 1 read, `addr1`=0x0100, `lbus_dr`=0xA5C3 during the strobe → `lbus_rd` low for 8 cycles. `rdata1`=0xA5C3 and `ack1` pulse at E0+16. `rdata0` is unchanged.
- Both reqs high in the same cycle after reset → master 0 is granted first, then master 1. Total of 2 acks, 18 cycles apart.
- Both reqs held continuously for 6 transactions → grants alternate 0,1,0,1,0,1. No strobe overlap.
- `rst` asserted at the 4th strobe-low cycle of a write → strobe is 1 and `busy`=0 at the next edge, with no `ack`. A fresh req then completes normally.
- SETUP=1, PULSE_W=1 → the strobe is low for exactly 1 cycle at E0+1 and `ack` arrives at E0+2. Back-to-back requests complete every 4 cycles.
